// File: rtl/idwt_image_write_if.sv
// idwt_image_write_if: coefficient stream in, RGB888 byte stream out.
interface idwt_image_write_if;
    logic              VSYNC;
    logic              HSYNC;
    logic signed [8:0] DATA_R_L, DATA_G_L, DATA_B_L;
    logic signed [8:0] DATA_R_H, DATA_G_H, DATA_B_H;
    logic              out_ready;
    logic              out_valid;
    logic [7:0]        out_byte;
    logic              out_last;

    modport master (
        output VSYNC, HSYNC, DATA_R_L, DATA_G_L, DATA_B_L, DATA_R_H, DATA_G_H, DATA_B_H, out_ready,
        input  out_valid, out_byte, out_last
    );

    modport slave (
        input  VSYNC, HSYNC, DATA_R_L, DATA_G_L, DATA_B_L, DATA_R_H, DATA_G_H, DATA_B_H, out_ready,
        output out_valid, out_byte, out_last
    );
endinterface

// File: rtl/idwt_image_write.sv
// idwt_image_write: inverse-Haar frame reconstruction and bottom-up RGB888 byte dump.
module idwt_image_write #(
    parameter int WIDTH  = 20,
    parameter int HEIGHT = 30,
    parameter int BYTES  = WIDTH*HEIGHT*3
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    idwt_image_write_if.slave bus,
    output logic              busy,
    output logic              frame_done,
    output logic              drop_err
);
    localparam int NPIX = WIDTH*HEIGHT;
    localparam int NP   = NPIX/2;
    localparam int AW   = $clog2(NPIX);
    localparam int PW   = $clog2(NP+1);
    localparam int KW   = $clog2(BYTES+1);
    localparam int JW   = $clog2(WIDTH);
    localparam logic [PW-1:0] P_FULL = PW'(NP);
    localparam logic [KW-1:0] K_END  = KW'(BYTES);
    localparam logic [KW-1:0] K_LAST = KW'(BYTES-1);
    localparam logic [JW-1:0] J_LAST = JW'(WIDTH-1);
    localparam logic [AW-1:0] A_TOP  = AW'(NPIX-WIDTH);
    localparam logic [AW-1:0] A_BACK = AW'(2*WIDTH-1);

    typedef enum logic [1:0] {IDLE, COLLECT, DUMP, DONE} state_t;

    state_t              state;
    logic [PW-1:0]       pair_cnt;
    logic                wr_en;
    logic [AW-2:0]       wr_pair;
    logic [2:0][7:0]     wr_ev, wr_od;
    logic [KW-1:0]       k;
    logic [AW-1:0]       rd_addr;
    logic [JW-1:0]       j;
    logic [1:0]          ch;
    logic [2:0][7:0]     mem [NPIX];
    logic                full, take, drop, load;

    function automatic logic [7:0] recon(input logic [8:0] l, input logic [8:0] h, input logic sub);
        logic signed [9:0] s;
        s = sub ? {l[8], l} - {h[8], h} : {l[8], l} + {h[8], h};
        return s < 10'sd0 ? 8'd0 : s > 10'sd255 ? 8'd255 : s[7:0];
    endfunction

    assign full = pair_cnt == P_FULL;
    assign take = bus.HSYNC && !bus.VSYNC && (state == IDLE || (state == COLLECT && !full));
    assign drop = bus.HSYNC && (state == DUMP || state == DONE || (state == COLLECT && full && !bus.VSYNC));
    assign load = state == DUMP && k != K_END && (!bus.out_valid || bus.out_ready);
    assign busy = state == COLLECT || state == DUMP;

    always_ff @(posedge HCLK)
        if (wr_en) begin
            mem[{wr_pair, 1'b0}] <= wr_ev;
            mem[{wr_pair, 1'b1}] <= wr_od;
        end

    // Output register is refilled ahead of the handshake; k counts bytes loaded into it.
    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) begin
            state         <= IDLE;
            pair_cnt      <= '0;
            wr_en         <= 1'b0;
            wr_pair       <= '0;
            wr_ev         <= '0;
            wr_od         <= '0;
            k             <= '0;
            rd_addr       <= '0;
            j             <= '0;
            ch            <= '0;
            bus.out_valid <= 1'b0;
            bus.out_byte  <= '0;
            bus.out_last  <= 1'b0;
            frame_done    <= 1'b0;
            drop_err      <= 1'b0;
        end else begin
            wr_en      <= take;
            frame_done <= 1'b0;
            drop_err   <= drop_err | drop;
            if (take) begin
                wr_pair  <= pair_cnt[AW-2:0];
                wr_ev    <= {recon(bus.DATA_B_L, bus.DATA_B_H, 1'b0), recon(bus.DATA_G_L, bus.DATA_G_H, 1'b0),
                             recon(bus.DATA_R_L, bus.DATA_R_H, 1'b0)};
                wr_od    <= {recon(bus.DATA_B_L, bus.DATA_B_H, 1'b1), recon(bus.DATA_G_L, bus.DATA_G_H, 1'b1),
                             recon(bus.DATA_R_L, bus.DATA_R_H, 1'b1)};
                pair_cnt <= pair_cnt + 1'b1;
            end
            if (load) begin
                bus.out_valid <= 1'b1;
                bus.out_byte  <= mem[rd_addr][ch];
                bus.out_last  <= k == K_LAST;
                k             <= k + 1'b1;
                ch            <= ch == 2'd2 ? 2'd0 : ch + 1'b1;
                if (ch == 2'd2) begin
                    j       <= j == J_LAST ? '0 : j + 1'b1;
                    rd_addr <= j == J_LAST ? rd_addr - A_BACK : rd_addr + 1'b1;
                end
            end
            case (state)
                IDLE:
                    if (bus.VSYNC) pair_cnt <= '0;
                    else if (bus.HSYNC) state <= COLLECT;
                COLLECT:
                    if (bus.VSYNC) begin
                        pair_cnt <= '0;
                        state    <= IDLE;
                    end else if (full) begin
                        state    <= DUMP;
                        pair_cnt <= '0;
                        k        <= '0;
                        rd_addr  <= A_TOP;
                        j        <= '0;
                        ch       <= '0;
                    end
                DUMP:
                    if (bus.out_valid && bus.out_ready && bus.out_last) begin
                        bus.out_valid <= 1'b0;
                        bus.out_last  <= 1'b0;
                        frame_done    <= 1'b1;
                        state         <= DONE;
                    end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_idwt_image_write.sv
// tb_idwt_image_write: scoreboard bench; frames are pushed as expected bytes, a monitor checks the dump.
module tb_idwt_image_write;
    localparam int W  = 20;
    localparam int H  = 30;
    localparam int NP = W*H/2;
    localparam int NB = W*H*3;

    logic HCLK = 1'b0;
    logic HRESETn;
    logic busy, frame_done, drop_err;

    idwt_image_write_if bus();

    idwt_image_write #(.WIDTH(W), .HEIGHT(H)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus),
        .busy(busy), .frame_done(frame_done), .drop_err(drop_err)
    );

    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic [7:0] b;
        logic       last;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         img[3][W*H];
    int         checks = 0, errors = 0, hs_cnt = 0, done_cnt = 0;
    bit         stall_armed = 1'b0;
    logic       pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [7:0] pb = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge HCLK) begin
        if (!HRESETn) pv = 1'b0;
        else begin
            if (pv && !pr) begin
                chk("hold_valid", 32'(bus.out_valid), 1);
                chk("hold_byte", 32'(bus.out_byte), 32'(pb));
                chk("hold_last", 32'(bus.out_last), 32'(pl));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0d, expected no byte", bus.out_byte);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("byte#%0d", hs_cnt), 32'(bus.out_byte), 32'(e.b));
                    chk($sformatf("last#%0d", hs_cnt), 32'(bus.out_last), 32'(e.last));
                end
                hs_cnt++;
            end
            if (frame_done) begin
                done_cnt++;
                chk("valid_at_done", 32'(bus.out_valid), 0);
            end
            pv = bus.out_valid;
            pr = bus.out_ready;
            pb = bus.out_byte;
            pl = bus.out_last;
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge HCLK);
            #1;
            if (stall_armed && hs_cnt == 37) begin
                bus.out_ready = 1'b0;
                repeat (5) @(posedge HCLK);
                #1;
                bus.out_ready = 1'b1;
                stall_armed = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        checks++;
        errors++;
        $display("FAIL timeout: got no end of test, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic drive(input bit vs, input bit hs, input int lr, hr, lg, hg, lb, hb);
        @(posedge HCLK);
        #1;
        bus.VSYNC    = vs;
        bus.HSYNC    = hs;
        bus.DATA_R_L = 9'(lr);
        bus.DATA_R_H = 9'(hr);
        bus.DATA_G_L = 9'(lg);
        bus.DATA_G_H = 9'(hg);
        bus.DATA_B_L = 9'(lb);
        bus.DATA_B_H = 9'(hb);
    endtask

    task automatic send_frame(input int seed, input int npairs, input bit special);
        int a[3], b[3], l[3], h[3];
        for (int p = 0; p < npairs; p++) begin
            for (int c = 0; c < 3; c++) begin
                a[c] = (p*7 + c*50 + seed*31) % 256;
                b[c] = (a[c] + 2*((p*3 + c + seed) % 50)) % 256;
                l[c] = (a[c] + b[c]) / 2;
                h[c] = (a[c] - b[c]) / 2;
                if (special && p == 0) begin l[c] = 150; h[c] = 50;   a[c] = 200; b[c] = 100; end
                if (special && p == 1) begin l[c] = 127; h[c] = -128; a[c] = 0;   b[c] = 255; end
                if (special && p == 2) begin l[c] = 255; h[c] = 255;  a[c] = 255; b[c] = 0;   end
                img[c][2*p]   = a[c];
                img[c][2*p+1] = b[c];
            end
            drive(1'b0, 1'b1, l[0], h[0], l[1], h[1], l[2], h[2]);
            if (p % 7 == 3) drive(1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
        end
        drive(1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
        if (npairs == NP)
            for (int k = 0; k < NB; k++) begin
                int fr, j, c;
                fr = k / (W*3);
                j  = (k % (W*3)) / 3;
                c  = k % 3;
                sb.push_back('{b: 8'(img[c][(H-1-fr)*W + j]), last: k == NB-1});
            end
    endtask

    task automatic wait_frame(input int hs0, input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 5000) begin
            @(posedge HCLK);
            n++;
        end
        repeat (4) @(posedge HCLK);
        #1;
        chk("frame_done_pulses", 32'(done_cnt - d0), 1);
        chk("handshakes", 32'(hs_cnt - hs0), NB);
        chk("queue_empty", 32'(sb.size()), 0);
        chk("idle_after_done", 32'(busy), 0);
    endtask

    initial begin
        int hs0, d0, n;
        bus.VSYNC = 1'b0;
        bus.HSYNC = 1'b0;
        {bus.DATA_R_L, bus.DATA_G_L, bus.DATA_B_L, bus.DATA_R_H, bus.DATA_G_H, bus.DATA_B_H} = '0;
        HRESETn = 1'b1;
        #1 HRESETn = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_byte", 32'(bus.out_byte), 0);
        chk("rst_out_last", 32'(bus.out_last), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_drop_err", 32'(drop_err), 0);
        @(negedge HCLK) HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        chk("idle_busy", 32'(busy), 0);

        hs0 = hs_cnt;
        d0  = done_cnt;
        stall_armed = 1'b1;
        send_frame(1, NP, 1'b1);
        wait_frame(hs0, d0);
        chk("stall_done", 32'(stall_armed), 0);
        chk("drop_err_clean", 32'(drop_err), 0);

        send_frame(2, 150, 1'b0);
        chk("partial_busy", 32'(busy), 1);
        drive(1'b1, 1'b1, 5, 5, 5, 5, 5, 5);
        drive(1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
        @(posedge HCLK);
        #1;
        chk("abort_idle", 32'(busy), 0);
        chk("abort_no_valid", 32'(bus.out_valid), 0);

        hs0 = hs_cnt;
        d0  = done_cnt;
        send_frame(3, NP, 1'b0);
        n = 0;
        while (hs_cnt < hs0 + 100 && n < 2000) begin
            @(posedge HCLK);
            n++;
        end
        drive(1'b0, 1'b1, 1, 2, 3, 4, 5, 6);
        drive(1'b0, 1'b1, 7, 8, 9, 10, 11, 12);
        drive(1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
        chk("drop_err_set", 32'(drop_err), 1);
        wait_frame(hs0, d0);
        chk("drop_err_sticky", 32'(drop_err), 1);

        hs0 = hs_cnt;
        send_frame(4, NP, 1'b0);
        n = 0;
        while (hs_cnt < hs0 + 500 && n < 3000) begin
            @(posedge HCLK);
            n++;
        end
        chk("reached_k500", 32'(hs_cnt - hs0), 500);
        #2 HRESETn = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus.out_valid), 0);
        chk("midrst_last", 32'(bus.out_last), 0);
        chk("midrst_byte", 32'(bus.out_byte), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_drop_err", 32'(drop_err), 0);
        sb.delete();
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;

        hs0 = hs_cnt;
        d0  = done_cnt;
        send_frame(5, NP, 1'b0);
        wait_frame(hs0, d0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
